// File: rtl/calc_seq_if.sv
// calc_seq_if: request/result handshake bundle for calc_seq_core
interface calc_seq_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             carry;
    logic             zero;
    logic             div0;
    logic             busy;
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result_lo, result_hi, carry, zero, div0, busy
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result_lo, result_hi, carry, zero, div0, busy
    );
endinterface

// File: rtl/calc_seq_core.sv
// calc_seq_core: handshaked unsigned calculator with iterative multiply/divide
module calc_seq_core #(parameter int WIDTH = 8) (
    input logic       clk,
    input logic       rst_n,
    calc_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_XOR = 3'd6;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state, state_nx;
    logic [2:0]       op_q, op_nx;
    logic [WIDTH-1:0] b_q, b_nx, lo, lo_nx, hi, hi_nx, div_diff;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             carry, carry_nx, zero, div0, div0_nx, div_ok;
    logic [WIDTH:0]   sum, mul_acc, div_sh;
    assign sum      = {1'b0, bus.a} + {1'b0, bus.b};
    // lo doubles as the shifting multiplier (MUL) or dividend/quotient (DIV)
    assign mul_acc  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    assign div_sh   = {hi, lo[WIDTH-1]};
    assign div_ok   = div_sh >= {1'b0, b_q};
    assign div_diff = div_sh[WIDTH-1:0] - b_q;
    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        b_nx     = b_q;
        lo_nx    = lo;
        hi_nx    = hi;
        cnt_nx   = cnt;
        carry_nx = carry;
        div0_nx  = div0;
        case (state)
            IDLE: if (bus.in_valid) begin
                op_nx    = bus.op;
                b_nx     = bus.b;
                hi_nx    = '0;
                carry_nx = 1'b0;
                div0_nx  = 1'b0;
                cnt_nx   = CW'(WIDTH);
                state_nx = DONE;
                case (bus.op)
                    OP_ADD: {carry_nx, lo_nx} = sum;
                    OP_SUB: begin
                        lo_nx    = bus.a - bus.b;
                        carry_nx = bus.a < bus.b;
                    end
                    OP_MUL: begin
                        lo_nx    = bus.a;
                        state_nx = BUSY;
                    end
                    OP_DIV: begin
                        lo_nx    = bus.b == '0 ? '1 : bus.a;
                        hi_nx    = bus.b == '0 ? bus.a : '0;
                        div0_nx  = bus.b == '0;
                        state_nx = bus.b == '0 ? DONE : BUSY;
                    end
                    OP_AND:  lo_nx = bus.a & bus.b;
                    OP_OR:   lo_nx = bus.a | bus.b;
                    OP_XOR:  lo_nx = bus.a ^ bus.b;
                    default: lo_nx = bus.a > bus.b ? bus.a : bus.b;
                endcase
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    {hi_nx, lo_nx} = {mul_acc, lo[WIDTH-1:1]};
                end else begin
                    hi_nx = div_ok ? div_diff : div_sh[WIDTH-1:0];
                    lo_nx = {lo[WIDTH-2:0], div_ok};
                end
                cnt_nx   = cnt - CW'(1);
                state_nx = cnt == CW'(1) ? DONE : BUSY;
            end
            default: state_nx = bus.out_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            b_q   <= '0;
            lo    <= '0;
            hi    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            state <= state_nx;
            op_q  <= op_nx;
            b_q   <= b_nx;
            lo    <= lo_nx;
            hi    <= hi_nx;
            cnt   <= cnt_nx;
            carry <= carry_nx;
            zero  <= (state == IDLE && !bus.in_valid) ? zero : lo_nx == '0;
            div0  <= div0_nx;
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state == BUSY;
    assign bus.result_lo = lo;
    assign bus.result_hi = hi;
    assign bus.carry     = carry;
    assign bus.zero      = zero;
    assign bus.div0      = div0;
endmodule
